// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the board-input conditioner (key FSM states,
// default debounce length).
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 10 ms at the 50 MHz board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/debounce_vec.sv
// Word-wide debouncer: a new synchronised value must hold unchanged for
// DEBOUNCE_CYCLES samples before it is published on q, with a one-cycle strobe.
module debounce_vec
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] d_sync,
    output logic [WIDTH-1:0] q,
    output logic             q_update
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] scnt;

    // Any bit change restarts the count for the whole word, so multi-bit
    // flips are accepted together once the word settles.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cand     <= '0;
            scnt     <= '0;
            q        <= '0;
            q_update <= 1'b0;
        end else begin
            q_update <= 1'b0;
            if (d_sync != cand) begin
                cand <= d_sync;
                scnt <= CNT_W'(1);
            end else if (cand != q) begin
                if (scnt == CNT_LAST) begin
                    q        <= cand;
                    q_update <= 1'b1;
                    scnt     <= '0;
                end else if (scnt != CNT_MAX) begin
                    scnt <= scnt + CNT_W'(1);
                end
            end else begin
                scnt <= '0;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the accumulate push-button and slide switches
// feeding the SoC PIO ports; all outputs are registered.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SW_WIDTH        = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                key_raw_n,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                accumulate_n,
    output logic                accumulate_pulse,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic                sw_update
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic                key_p0, key_p1;
    logic [SW_WIDTH-1:0] sw_p0, sw_p1;

    // Two-flop synchronisers; the key idles released (high)
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            key_p0 <= key_raw_n;
            key_p1 <= key_p0;
            sw_p0  <= sw_raw;
            sw_p1  <= sw_p0;
        end
    end

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             acc_n_nxt, pulse_nxt;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            accumulate_n     <= 1'b1;
            accumulate_pulse <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            accumulate_n     <= acc_n_nxt;
            accumulate_pulse <= pulse_nxt;
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (!key_p1) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (key_p1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSED: begin
                if (key_p1) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!key_p1) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        acc_n_nxt = !((state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT));
        pulse_nxt = (state == PRESS_WAIT) && (state_nxt == PRESSED);
    end

    debounce_vec #(
        .WIDTH          (SW_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d_sync  (sw_p1),
        .q       (sw_stable),
        .q_update(sw_update)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed timing scenarios plus random bouncy
// stimulus against a run-length reference model.
module tb_input_conditioner;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       key_raw_n = 1'b0;
    logic [7:0] sw_raw = 8'hFF;
    logic       accumulate_n, accumulate_pulse, sw_update;
    logic [7:0] sw_stable;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .SW_WIDTH       (8)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .key_raw_n       (key_raw_n),
        .sw_raw          (sw_raw),
        .accumulate_n    (accumulate_n),
        .accumulate_pulse(accumulate_pulse),
        .sw_stable       (sw_stable),
        .sw_update       (sw_update)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: inputs are seen two edges late; a level is accepted
    // once D consecutive identical samples differ from the accepted one.
    logic       mk_d0, mk_d1, m_acc_n, m_pulse, m_upd;
    logic [7:0] ms_d0, ms_d1, ms_prev, m_stable;
    int         mk_run, ms_run;

    task automatic model_edge(input logic rn, input logic k, input logic [7:0] s);
        logic       ks;
        logic [7:0] ss;
        if (!rn) begin
            mk_d0 = 1'b1; mk_d1 = 1'b1; ms_d0 = '0; ms_d1 = '0;
            m_acc_n = 1'b1; m_pulse = 1'b0; mk_run = 0;
            ms_prev = '0; m_stable = '0; ms_run = 0; m_upd = 1'b0;
        end else begin
            ks = mk_d1; ss = ms_d1;
            mk_d1 = mk_d0; mk_d0 = k;
            ms_d1 = ms_d0; ms_d0 = s;
            m_pulse = 1'b0;
            if (ks != m_acc_n) begin
                mk_run++;
                if (mk_run == D) begin
                    m_acc_n = ks;
                    m_pulse = !ks;
                    mk_run  = 0;
                end
            end else begin
                mk_run = 0;
            end
            m_upd = 1'b0;
            if (ss != m_stable) begin
                ms_run = (ss == ms_prev) ? ms_run + 1 : 1;
                if (ms_run == D) begin
                    m_stable = ss;
                    m_upd    = 1'b1;
                    ms_run   = 0;
                end
            end
            ms_prev = ss;
        end
    endtask

    task automatic step(input logic rn, input logic k, input logic [7:0] s);
        @(negedge Clk);
        Reset_n = rn; key_raw_n = k; sw_raw = s;
        @(posedge Clk);
        model_edge(rn, k, s);
        #1;
        chk("accumulate_n", 32'(accumulate_n), 32'(m_acc_n));
        chk("accumulate_pulse", 32'(accumulate_pulse), 32'(m_pulse));
        chk("sw_stable", 32'(sw_stable), 32'(m_stable));
        chk("sw_update", 32'(sw_update), 32'(m_upd));
    endtask

    int         pidx, pcnt, eidx, ecnt, uidx, ucnt;
    logic       rk;
    int         hold;
    logic [7:0] rs;
    logic       rrn;
    logic [7:0] bounce [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset with inputs active
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hFF);
        chk("rst_acc_n", 32'(accumulate_n), 32'd1);
        chk("rst_sw_stable", 32'(sw_stable), 32'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h00);

        // Clean press
        pidx = -1; pcnt = 0; eidx = -1;
        for (int e = 0; e < 10; e++) begin
            step(1'b1, 1'b0, 8'h00);
            if (accumulate_pulse) begin pcnt++; pidx = e; end
            if (!accumulate_n && eidx < 0) eidx = e;
        end
        chk("press_pulse_edge", 32'(pidx), 32'd5);
        chk("press_pulse_cnt", 32'(pcnt), 32'd1);
        chk("press_low_edge", 32'(eidx), 32'd5);

        // Release
        pcnt = 0; eidx = -1;
        for (int e = 0; e < 10; e++) begin
            step(1'b1, 1'b1, 8'h00);
            if (accumulate_pulse) pcnt++;
            if (accumulate_n && eidx < 0) eidx = e;
        end
        chk("release_high_edge", 32'(eidx), 32'd5);
        chk("release_pulse_cnt", 32'(pcnt), 32'd0);

        // Bounce shorter than D
        pcnt = 0; ecnt = 0;
        for (int e = 0; e < 13; e++) begin
            step(1'b1, (e < 5) ? bounce[e][0] : 1'b1, 8'h00);
            if (accumulate_pulse) pcnt++;
            if (!accumulate_n) ecnt++;
        end
        chk("bounce_pulse_cnt", 32'(pcnt), 32'd0);
        chk("bounce_low_cycles", 32'(ecnt), 32'd0);

        // Long hold: one pulse only
        pcnt = 0;
        for (int e = 0; e < 100; e++) begin
            step(1'b1, 1'b0, 8'h00);
            if (accumulate_pulse) pcnt++;
        end
        chk("hold_pulse_cnt", 32'(pcnt), 32'd1);
        for (int e = 0; e < 10; e++) step(1'b1, 1'b1, 8'h00);

        // Switch change
        uidx = -1; ucnt = 0;
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b1, 8'hA5);
            if (sw_update) begin ucnt++; uidx = e; end
        end
        chk("sw_update_edge", 32'(uidx), 32'd5);
        chk("sw_update_cnt", 32'(ucnt), 32'd1);
        chk("sw_value", 32'(sw_stable), 32'hA5);

        // Bit 0 glitch mid-count restarts the word
        uidx = -1; ucnt = 0;
        for (int e = 0; e < 12; e++) begin
            step(1'b1, 1'b1, (e == 2) ? 8'h3D : 8'h3C);
            if (sw_update) begin ucnt++; uidx = e; end
        end
        chk("sw_glitch_edge", 32'(uidx), 32'd8);
        chk("sw_glitch_cnt", 32'(ucnt), 32'd1);
        chk("sw_glitch_value", 32'(sw_stable), 32'h3C);

        // Key and switches completing together
        pidx = -1; uidx = -1;
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b0, 8'h0F);
            if (accumulate_pulse) pidx = e;
            if (sw_update) uidx = e;
        end
        chk("both_key_edge", 32'(pidx), 32'd5);
        chk("both_sw_edge", 32'(uidx), 32'd5);
        for (int e = 0; e < 10; e++) step(1'b1, 1'b1, 8'h0F);

        // Reset at edge 3 of a press, key kept low
        pidx = -1; pcnt = 0;
        for (int e = 0; e < 13; e++) begin
            step((e != 3), 1'b0, 8'h0F);
            if (accumulate_pulse) begin pcnt++; pidx = e; end
        end
        chk("rst_mid_pulse_edge", 32'(pidx), 32'd9);
        chk("rst_mid_pulse_cnt", 32'(pcnt), 32'd1);
        for (int e = 0; e < 10; e++) step(1'b1, 1'b1, 8'h0F);

        // Random bouncy stimulus against the model
        rk = 1'b1; hold = 0; rs = 8'h0F;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rk   = ~rk;
                hold = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) rs = 8'($urandom);
            else if ($urandom_range(0, 15) == 0) rs = rs ^ (8'h01 << $urandom_range(0, 7));
            rrn = ($urandom_range(0, 299) != 0);
            step(rrn, rk, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
